// File: rtl/hyp_pkg.sv
// Shared constants for the hypotenuse coprocessor: FSM encoding, latencies and
// width helpers so the top and the root engine agree on sizes for any W.
package hyp_pkg;

  localparam int HYP_W = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SQ_A = 2'd1;
  localparam logic [1:0] SQ_B = 2'd2;
  localparam logic [1:0] SQRT = 2'd3;

  localparam int SQ_CYCLES   = HYP_W;
  localparam int SQRT_CYCLES = HYP_W + 1;
  localparam int BUSY_CYCLES = 3 * HYP_W + 1;
  localparam int SUM_W       = 2 * HYP_W + 1;
  localparam int REM_W       = HYP_W + 3;

  function automatic int f_sum_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int f_rem_w(input int w);
    return w + 3;
  endfunction

endpackage

// File: rtl/hyp_unit_isqrt_seq.sv
// Restoring digit-by-digit integer square root: one root bit per cycle, MSB first.
// o_done flags the final iteration so the parent can capture o_root_nxt on that edge.
module isqrt_seq
  import hyp_pkg::*;
#(
  parameter int W = HYP_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_load,
  input  logic [2*W+1:0] i_rad,
  output logic [W:0]     o_root_nxt,
  output logic           o_done
);

  localparam int RW = f_rem_w(W);
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W);

  logic [2*W+1:0] r_rad;
  logic [RW-1:0]  r_rem;
  logic [W:0]     r_root;
  logic [CW-1:0]  r_cnt;
  logic           r_run;

  logic [RW+1:0]  w_trial_rem;
  logic [RW+1:0]  w_trial;
  logic           w_fit;
  logic [RW-1:0]  w_rem_nxt;

  // Remainder stays below 2*root+1, so truncating back to RW bits is lossless.
  always_comb begin
    w_trial_rem = {r_rem, r_rad[2*W+1 -: 2]};
    w_trial     = (RW+2)'({r_root, 2'b01});
    w_fit       = (w_trial_rem >= w_trial);
    w_rem_nxt   = w_fit ? RW'(w_trial_rem - w_trial) : RW'(w_trial_rem);
    o_root_nxt  = {r_root[W-1:0], w_fit};
    o_done      = r_run && (r_cnt == LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rad  <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
    end else if (i_load) begin
      r_rad  <= i_rad;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b1;
    end else if (r_run) begin
      r_rad  <= r_rad << 2;
      r_rem  <= w_rem_nxt;
      r_root <= o_root_nxt;
      if (r_cnt == LAST) begin
        r_cnt <= '0;
        r_run <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hyp_unit.sv
// Start/busy coprocessor computing floor(sqrt(a*a + b*b)): two shift-add squarings
// sharing one adder, then the sequential root engine. Result held until next completion.
module hyp_unit
  import hyp_pkg::*;
#(
  parameter int W = HYP_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [W-1:0] a_bi,
  input  logic [W-1:0] b_bi,
  output logic [W:0]   y_bo,
  output logic         busy_o
);

  localparam int AW = f_sum_w(W);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] SQ_LAST = CW'(W - 1);

  logic [1:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic [AW-1:0]  r_sum;
  logic [2*W-1:0] r_addend;
  logic [W-1:0]   r_mplier;
  logic [W-1:0]   r_b;
  logic [W:0]     r_y;
  logic           r_busy;

  logic [AW-1:0]  w_sum_nxt;
  logic           w_load;
  logic [W:0]     w_root_nxt;
  logic           w_done;

  always_comb begin
    w_sum_nxt = r_sum + AW'(r_mplier[0] ? r_addend : '0);
    w_load    = (r_state == SQ_B) && (r_cnt == SQ_LAST);
  end

  isqrt_seq #(.W(W)) u_isqrt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_rad      ((2*W+2)'(w_sum_nxt)),
    .o_root_nxt (w_root_nxt),
    .o_done     (w_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_addend <= '0;
      r_mplier <= '0;
      r_b      <= '0;
      r_y      <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_addend <= (2*W)'(a_bi);
            r_mplier <= a_bi;
            r_b      <= b_bi;
            r_sum    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= SQ_A;
          end
        end
        SQ_A, SQ_B: begin
          r_sum    <= w_sum_nxt;
          r_addend <= r_addend << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          // Last multiplier bit: reload the shifter with b, or hand off to the root engine.
          if (r_cnt == SQ_LAST) begin
            r_cnt <= '0;
            if (r_state == SQ_A) begin
              r_addend <= (2*W)'(r_b);
              r_mplier <= r_b;
              r_state  <= SQ_B;
            end else begin
              r_state  <= SQRT;
            end
          end
        end
        SQRT: begin
          if (w_done) begin
            r_y     <= w_root_nxt;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign y_bo   = r_y;
  assign busy_o = r_busy;

endmodule

// File: doc/hyp_unit.md
Name: hyp_unit

Overview:
Multi-cycle coprocessor that computes the integer hypotenuse y = floor(sqrt(a*a + b*b)) of two unsigned 8-bit operands. It is the responder side of the CPU's start/busy math-unit handshake. The control unit pulses start and stalls the PC while busy is high. It writes y into rd in the first cycle after busy falls. The datapath has two sequential shift-add squarings followed by a digit-by-digit integer square root.

Parameters:
- W, 8: operand width. The result is W+1 bits. Busy latency is W + W + (W+1) cycles.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous and active-low.
- start_i  in  1  request. Sampled only in IDLE.
- a_bi  in  W  operand a. Sampled on the accepting edge only.
- b_bi  in  W  operand b. Sampled on the accepting edge only.
- y_bo  out  W+1  result. Registered.
- busy_o  out  1  high while a computation is in progress. Registered.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, busy_o=0, y_bo=0, all internal registers 0.
  - Reset wins over everything, including mid-operation. The partial result is discarded and y_bo returns to 0.
- States: IDLE -> SQ_A -> SQ_B -> SQRT -> IDLE.
- IDLE, start_i=1 at edge T:
  - Latch a_bi and b_bi, clear the accumulator, go to SQ_A.
  - busy_o=1 from cycle T+1.
- SQ_A, W cycles: shift-add a*a into the 2W+1-bit sum accumulator, one multiplier bit per cycle, LSB first.
- SQ_B, W cycles: shift-add b*b, added into the same accumulator.
  - Maximum sum is 2*(2^W-1)^2 = 130050 for W=8, so it fits in 2W+1 bits with no overflow.
- SQRT, W+1 cycles: restoring digit-by-digit square root of the sum, zero-extended to 2W+2 bits.
  - Each cycle consumes 2 radicand bits and produces 1 root bit, MSB first.
  - Remainder register is W+3 bits.
- On the last SQRT edge: y_bo <= root, busy_o <= 0, state <= IDLE.
- Total busy_o-high time is exactly 3W+1 cycles (25 for W=8): T+1 through T+3W+1.
  - y_bo is valid in cycle T+3W+2, the first cycle with busy_o=0. The CPU writes back in that cycle.
- y_bo is held stable from completion until the next completion or reset. It does not change during a new computation.
- start_i while busy_o=1 is ignored. The CPU re-asserts start in the cycle after acceptance, and this must not restart or extend the operation.
- Operand changes while busy have no effect.
- start_i=1 in the cycle busy_o first reads 0 is a new request and is accepted. Back-to-back operations have no dead cycle.
- Exactness: y_bo = floor(sqrt(a^2+b^2)) for all 2^(2W) operand pairs. No rounding.
- No X on outputs after reset. All outputs come straight from flops; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package (hyp_pkg):
  - State encoding localparams: IDLE, SQ_A, SQ_B, SQRT, 2 bits.
  - Latency constants: SQ_CYCLES=W, SQRT_CYCLES=W+1, BUSY_CYCLES=3W+1.
  - Derived widths: SUM_W=2W+1, REM_W=W+3.
- One sub-module, isqrt_seq: iterative restoring square root.
  - Handshake: load pulse, radicand in, root out, done pulse.
  - The parent FSM owns busy_o and y_bo, and launches isqrt_seq at SQ_B exit.
- The squaring shift-add stays inline in the parent; it shares one adder and counter between SQ_A and SQ_B.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 -> busy_o=0, y_bo=0. busy_o stays 0 with start_i=0.
- a=3, b=4, start pulse at T -> busy_o=1 for cycles T+1..T+25, y_bo=5 at T+26. y_bo unchanged during busy.
- Corners, each as separate run:
  - a=0, b=0 -> 0.
  - a=1, b=1 -> 1.
  - a=255, b=0 -> 255.
  - a=255, b=255 -> 360.
  - a=200, b=150 -> 250.
- CPU-style handshake: start high at T and T+1 with operands changed at T+1 (a=6, b=8 then a=9, b=9) -> single 25-cycle busy, y_bo=10. Then start at the first busy_o=0 cycle with a=5, b=12 -> accepted immediately, y_bo=13 after a further 25 busy cycles.
- Reset mid-operation: start a=255, b=255, drop rst_n at busy cycle 12 -> next cycle busy_o=0, y_bo=0. A fresh a=3, b=4 afterwards returns 5 with nominal latency.
- Exhaustive random sweep: 10k random (a,b) with random idle gaps 0..3 cycles -> y_bo matches the floor-sqrt model and every busy window is exactly 25 cycles.
